// File: rtl/conv_rescaler.sv
// Maps signed convolution samples to 0..255 pixels using per-frame min/max and a sequential divider.
// Latency 2 cycles accept->o_valid; o_ready low outside RUN. Optional RESCALER_ROUND_EN selects round-half-up.
module conv_rescaler #(
    parameter int NB_PIXEL = 19,
    parameter int NB_COUNT = 32,
    parameter int NB_OUT   = 8,
    parameter int NB_FRAC  = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                i_extremesValid,
    input  logic [NB_PIXEL-1:0] i_maxValue,
    input  logic [NB_PIXEL-1:0] i_minValue,
    input  logic [NB_COUNT-1:0] i_imageSize,
    input  logic                i_valid,
    input  logic [NB_PIXEL-1:0] i_convValue,
    output logic                o_ready,
    output logic [NB_OUT-1:0]   o_pixel,
    output logic                o_valid,
    output logic                o_endSignal
);
    localparam int NB_RANGE = NB_PIXEL + 1;
    localparam int NB_SCALE = NB_OUT + NB_FRAC;
    localparam int NB_PROD  = NB_RANGE + NB_SCALE;
    localparam int NB_BIT   = $clog2(NB_SCALE);
    localparam logic [NB_BIT-1:0]   BIT_LAST = NB_BIT'(NB_SCALE - 1);
    localparam logic [NB_SCALE-1:0] DIVIDEND = {{NB_OUT{1'b1}}, {NB_FRAC{1'b0}}};
`ifdef RESCALER_ROUND_EN
    localparam logic [NB_PROD:0] ROUND = (NB_PROD+1)'(1) << (NB_FRAC - 1);
`else
    localparam logic [NB_PROD:0] ROUND = '0;
`endif

    typedef enum logic [1:0] {IDLE, DIVIDE, RUN, DRAIN} state_t;

    state_t                       state_q, state_d;
    logic signed [NB_PIXEL-1:0]   min_q, min_d;
    logic [NB_COUNT-1:0]          size_q, size_d, count_q, count_d;
    logic [NB_RANGE-1:0]          range_q, range_d;
    logic [NB_SCALE-1:0]          scale_q, scale_d;
    logic [NB_RANGE-1:0]          rem_q, rem_d;
    logic [NB_BIT-1:0]            bit_q, bit_d;

    logic                         s1_vld_q, s1_last_q, s2_vld_q, s2_last_q;
    logic [NB_RANGE-1:0]          diff_q, diff_d;
    logic [NB_PROD-1:0]           prod_q;
    logic                         vld_q, end_q;
    logic [NB_OUT-1:0]            pixel_q, pixel_d;

    logic                         accept, last_acc, lone_end;
    logic signed [NB_RANGE-1:0]   span, delta;
    logic [NB_RANGE-1:0]          span_pos;
    logic [NB_RANGE:0]            rem_shift;
    logic [NB_PROD:0]             rounded, shifted;

    assign accept   = i_valid && (state_q == RUN);
    assign last_acc = accept && ((count_q + NB_COUNT'(1)) == size_q);

    // Extend by one bit so max-min and conv-min never overflow.
    assign span     = {i_maxValue[NB_PIXEL-1], i_maxValue} - {i_minValue[NB_PIXEL-1], i_minValue};
    assign span_pos = (span > 0) ? NB_RANGE'(span) : '0;
    assign delta    = {i_convValue[NB_PIXEL-1], i_convValue} - {min_q[NB_PIXEL-1], min_q};
    assign rem_shift = {rem_q, scale_q[NB_SCALE-1]};

    always_comb begin
        diff_d = NB_RANGE'(delta);
        if (delta < 0)
            diff_d = '0;
        else if (NB_RANGE'(delta) > range_q)
            diff_d = range_q;
    end

    always_comb begin
        rounded = {1'b0, prod_q} + ROUND;
        shifted = rounded >> NB_FRAC;
        pixel_d = (|shifted[NB_PROD:NB_OUT]) ? '1 : shifted[NB_OUT-1:0];
    end

    always_comb begin
        state_d  = state_q;
        min_d    = min_q;
        size_d   = size_q;
        count_d  = count_q;
        range_d  = range_q;
        scale_d  = scale_q;
        rem_d    = rem_q;
        bit_d    = bit_q;
        lone_end = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_extremesValid) begin
                    min_d   = i_minValue;
                    size_d  = i_imageSize;
                    range_d = span_pos;
                    count_d = '0;
                    rem_d   = '0;
                    bit_d   = '0;
                    if (i_imageSize == '0) begin
                        lone_end = 1'b1;
                    end else if (span_pos != '0) begin
                        scale_d = DIVIDEND;
                        state_d = DIVIDE;
                    end else begin
                        scale_d = '0;
                        state_d = RUN;
                    end
                end
            end
            DIVIDE: begin
                // Restoring division: dividend shifts out of scale while quotient bits shift in.
                if (rem_shift >= {1'b0, range_q}) begin
                    rem_d   = NB_RANGE'(rem_shift - {1'b0, range_q});
                    scale_d = {scale_q[NB_SCALE-2:0], 1'b1};
                end else begin
                    rem_d   = NB_RANGE'(rem_shift);
                    scale_d = {scale_q[NB_SCALE-2:0], 1'b0};
                end
                bit_d = bit_q + NB_BIT'(1);
                if (bit_q == BIT_LAST)
                    state_d = RUN;
            end
            RUN: begin
                if (accept)
                    count_d = count_q + NB_COUNT'(1);
                if (last_acc)
                    state_d = DRAIN;
            end
            DRAIN: begin
                if (end_q) begin
                    count_d = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            min_q   <= '0;
            size_q  <= '0;
            count_q <= '0;
            range_q <= '0;
            scale_q <= '0;
            rem_q   <= '0;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            min_q   <= min_d;
            size_q  <= size_d;
            count_q <= count_d;
            range_q <= range_d;
            scale_q <= scale_d;
            rem_q   <= rem_d;
            bit_q   <= bit_d;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_vld_q  <= 1'b0;
            s1_last_q <= 1'b0;
            diff_q    <= '0;
            s2_vld_q  <= 1'b0;
            s2_last_q <= 1'b0;
            prod_q    <= '0;
            vld_q     <= 1'b0;
            end_q     <= 1'b0;
            pixel_q   <= '0;
        end else begin
            s1_vld_q  <= accept;
            s1_last_q <= last_acc;
            if (accept)
                diff_q <= diff_d;
            s2_vld_q  <= s1_vld_q;
            s2_last_q <= s1_last_q;
            if (s1_vld_q)
                prod_q <= NB_PROD'(diff_q) * NB_PROD'(scale_q);
            vld_q     <= s2_vld_q;
            end_q     <= (s2_vld_q && s2_last_q) || lone_end;
            if (s2_vld_q)
                pixel_q <= pixel_d;
        end
    end

    assign o_ready     = (state_q == RUN);
    assign o_pixel     = pixel_q;
    assign o_valid     = vld_q;
    assign o_endSignal = end_q;
endmodule

// File: tb/tb_conv_rescaler.sv
// Randomized frame stimulus checked against an arithmetic model of the rescaling rule.
module tb_conv_rescaler;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        i_extremesValid = 1'b0;
    logic [18:0] i_maxValue = '0, i_minValue = '0, i_convValue = '0;
    logic [31:0] i_imageSize = '0;
    logic        i_valid = 1'b0;
    logic        o_ready, o_valid, o_endSignal;
    logic [7:0]  o_pixel;

    conv_rescaler dut (
        .clock(clock), .reset(reset), .i_extremesValid(i_extremesValid),
        .i_maxValue(i_maxValue), .i_minValue(i_minValue), .i_imageSize(i_imageSize),
        .i_valid(i_valid), .i_convValue(i_convValue), .o_ready(o_ready),
        .o_pixel(o_pixel), .o_valid(o_valid), .o_endSignal(o_endSignal)
    );

    always #5 clock = ~clock;

    typedef struct { longint pix; bit last; longint cyc; } exp_t;
    exp_t   exp_q[$];
    int     conv_tab[$];
    longint cyc = 0;
    int     checks = 0, failures = 0;
    int     out_cnt = 0, end_cnt = 0;
    bit     allow_lone = 1'b0;
    longint cur_min, cur_rng, cur_scale;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic longint model_pix(input longint c);
        longint d, p;
        d = c - cur_min;
        if (d < 0) d = 0;
        if (d > cur_rng) d = cur_rng;
        p = d * cur_scale;
`ifdef RESCALER_ROUND_EN
        p = p + 32768;
`endif
        p = p / 65536;
        if (p > 255) p = 255;
        return p;
    endfunction

    always @(negedge clock) begin : mon
        exp_t e;
        if (reset) begin
            if (o_valid) begin
                out_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("pixel", o_pixel, e.pix);
                    chk("latency", cyc, e.cyc + 2);
                    chk("end_with_valid", o_endSignal, e.last);
                end
            end else if (o_endSignal) begin
                chk("lone_end_allowed", allow_lone, 1);
            end
            if (o_endSignal) end_cnt++;
        end
    end

    task automatic do_reset_check(input string tag);
        chk({tag, "_ready"}, o_ready, 0);
        chk({tag, "_pixel"}, o_pixel, 0);
        chk({tag, "_valid"}, o_valid, 0);
        chk({tag, "_end"},   o_endSignal, 0);
    endtask

    task automatic run_frame(input int mn, input int mx, input int sz, input int vmode,
                             input int inject_at, input int abort_at);
        longint pulse_edge, lo, hi;
        int n, g, end0, out0, c, q0;
        bit v;
        cur_min   = mn;
        cur_rng   = (mx > mn) ? longint'(mx) - mn : 0;
        cur_scale = (cur_rng > 0) ? (longint'(255) * 65536) / cur_rng : 0;
        end0 = end_cnt;
        out0 = out_cnt;
        allow_lone = (sz == 0);
        @(posedge clock); #1;
        i_extremesValid = 1'b1;
        i_maxValue = 19'(mx); i_minValue = 19'(mn); i_imageSize = 32'(sz);
        pulse_edge = cyc + 1;
        @(posedge clock); #1;
        i_extremesValid = 1'b0;
        if (sz == 0) begin
            @(posedge clock); #1;
            chk("zero_size_ready", o_ready, 0);
            repeat (2) @(posedge clock);
            #1;
            chk("zero_size_ends", end_cnt - end0, 1);
            chk("zero_size_valids", out_cnt - out0, 0);
            allow_lone = 1'b0;
            return;
        end
        g = 0;
        while (!o_ready && g < 100) begin
            @(posedge clock); #1;
            g++;
        end
        chk("ready_time", cyc, pulse_edge + ((cur_rng > 0) ? 24 : 0));
        lo = (mn < mx) ? mn : mx;
        hi = (mn < mx) ? mx : mn;
        lo = (lo - 40 < -262144) ? -262144 : lo - 40;
        hi = (hi + 40 > 262143) ? 262143 : hi + 40;
        n = 0;
        g = 0;
        while (n < sz && g < 20000) begin
            if (abort_at > 0 && n == abort_at) begin
                reset = 1'b0;
                #1;
                do_reset_check("mid_reset");
                exp_q.delete();
                i_valid = 1'b0;
                repeat (2) @(posedge clock);
                #1;
                reset = 1'b1;
                q0 = out_cnt + end_cnt;
                repeat (6) @(posedge clock);
                #1;
                chk("post_reset_quiet", out_cnt + end_cnt - q0, 0);
                chk("post_reset_ready", o_ready, 0);
                return;
            end
            i_extremesValid = (inject_at > 0 && n == inject_at);
            i_minValue = 19'(mn + 3); i_maxValue = 19'(mn + 4); i_imageSize = 32'd1;
            case (vmode)
                0: v = 1'b1;
                1: v = (g % 2 == 0);
                default: v = ($urandom_range(99) < 70);
            endcase
            c = (v && o_ready && conv_tab.size() > 0) ? conv_tab.pop_front()
                                                      : int'(lo + $urandom_range(int'(hi - lo)));
            i_valid = v;
            i_convValue = 19'(c);
            if (v && o_ready) begin
                exp_q.push_back('{model_pix(c), (n + 1 == sz), cyc + 1});
                n++;
            end
            @(posedge clock); #1;
            g++;
        end
        i_extremesValid = 1'b0;
        chk("accepted_all", n, sz);
        chk("ready_drop", o_ready, 0);
        repeat (3) begin
            i_valid = 1'b1;
            i_convValue = 19'($urandom_range(1000));
            @(posedge clock); #1;
        end
        i_valid = 1'b0;
        g = 0;
        while (end_cnt == end0 && g < 30) begin
            @(posedge clock); #1;
            g++;
        end
        repeat (2) @(posedge clock);
        #1;
        chk("end_count", end_cnt - end0, 1);
        chk("out_count", out_cnt - out0, sz);
        chk("queue_empty", exp_q.size(), 0);
    endtask

    initial begin
        repeat (3) @(posedge clock);
        #1;
        do_reset_check("reset");
        reset = 1'b1;

        conv_tab = '{0, 100, 255, 300};
        run_frame(0, 255, 4, 0, 0, 0);
        conv_tab = '{-1, 49, 99};
        run_frame(-1, 99, 3, 0, 0, 0);
        conv_tab = '{5, 5, -7};
        run_frame(5, 5, 3, 0, 0, 0);
        conv_tab.delete();
        for (int i = 0; i < 50; i++) begin
            conv_tab.push_back(-50);
            conv_tab.push_back(200);
        end
        run_frame(0, 100, 100, 1, 0, 0);
        conv_tab.delete();
        run_frame(10, 20, 0, 0, 0, 0);
        run_frame(-262144, 262143, 12, 2, 0, 0);
        run_frame(300, -200, 6, 2, 0, 0);
        for (int f = 0; f < 4; f++) begin
            int mn, mx;
            mn = int'($urandom_range(2000)) - 1000;
            mx = mn + int'($urandom_range(3000)) - 200;
            run_frame(mn, mx, 1 + int'($urandom_range(19)), 2, (f == 1) ? 1 : 0, 0);
        end
        run_frame(-30, 70, 50, 0, 0, 10);
        run_frame(-30, 70, 8, 2, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
